// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP32 add/subtract sequencer: unpack/align, add, iterative normalise, round.
// Defining FP_ADDSUB_PERF_EN adds the perf_ops / perf_stall counter ports.
module fp_addsub_seq #(
    parameter int NORM_MAX = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic [2:0]  rm,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags,
`ifdef FP_ADDSUB_PERF_EN
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall,
`endif
    output logic        busy
);

    localparam int CNT_W = $clog2(NORM_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NORM_MAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [2:0]       state_q;
    logic [31:0]      a_q, b_q;
    logic [2:0]       rm_q;
    logic [47:0]      big_q, small_q;
    logic             sign_big_q, sign_small_q, sign_q, zero_q;
    logic [48:0]      sum_q;
    logic [9:0]       exp_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Unpack, special-case detection and alignment of the smaller operand.
    logic [7:0]  ea, eb, e_big, e_small, e_diff;
    logic [23:0] ma, mb, m_small;
    logic        a_nan, b_nan, a_inf, b_inf, any_snan, a_first, special, small_lost;
    logic [5:0]  shamt;
    logic [47:0] small_full, small_shift;
    logic [31:0] special_res;
    logic [4:0]  special_flags;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        special_res   = QNAN;
        special_flags = 5'd0;
        ea       = a_q[30:23];
        eb       = b_q[30:23];
        ma       = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
        mb       = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
        a_nan    = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan    = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf    = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf    = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        any_snan = (a_nan && !a_q[22]) || (b_nan && !b_q[22]);
        special  = a_nan || b_nan || a_inf || b_inf;
        if (a_nan || b_nan) begin
            special_flags = {any_snan, 4'd0};
        end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
            special_flags = 5'b10000;
        end else if (a_inf) begin
            special_res = a_q;
        end else if (b_inf) begin
            special_res = b_q;
        end
        a_first     = (ea >= eb);
        e_big       = a_first ? ea : eb;
        e_small     = a_first ? eb : ea;
        m_small     = a_first ? mb : ma;
        e_diff      = e_big - e_small;
        shamt       = (e_diff >= 8'd48) ? 6'd48 : e_diff[5:0];
        small_full  = {m_small, 24'd0};
        small_shift = small_full >> shamt;
        small_lost  = |(small_full & ~(48'hFFFF_FFFF_FFFF << shamt));
    end

    // Signed-magnitude add/subtract of the aligned mantissas.
    logic [48:0] add_sum;
    logic        add_sign;

    always_comb begin
        add_sum  = {1'b0, big_q} + {1'b0, small_q};
        add_sign = sign_big_q;
        if (sign_big_q != sign_small_q) begin
            if (big_q >= small_q) begin
                add_sum = {1'b0, big_q - small_q};
            end else begin
                add_sum  = {1'b0, small_q - big_q};
                add_sign = sign_small_q;
            end
        end
    end

    // Rounding: mantissa in [47:24], guard/round at [23]/[22], sticky below.
    logic        g, r, s, grs, inc, ovf_inf;
    logic [24:0] mant_r;
    logic [9:0]  exp_r;
    logic [22:0] frac_r;
    logic [31:0] round_res;
    logic [4:0]  round_flags;

    always_comb begin
        g   = sum_q[23];
        r   = sum_q[22];
        s   = |sum_q[21:0];
        grs = g | r | s;
        case (rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_q & grs;
            RM_RUP:  inc = ~sign_q & grs;
            RM_RMM:  inc = g;
            default: inc = g & (r | s | sum_q[24]);
        endcase
        mant_r  = {1'b0, sum_q[47:24]} + {24'd0, inc};
        exp_r   = exp_q + {9'd0, mant_r[24]};
        frac_r  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        ovf_inf = (rm_q == RM_RTZ) ? 1'b0 : (rm_q == RM_RDN) ? sign_q :
                  (rm_q == RM_RUP) ? ~sign_q : 1'b1;
        if (zero_q) begin
            round_res   = {sign_q, 31'd0};
            round_flags = 5'd0;
        end else if (!sum_q[47]) begin
            round_res   = {sign_q, 31'd0};
            round_flags = 5'b00011;
        end else if (exp_r >= 10'd255) begin
            round_res   = ovf_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'hFE, 23'h7FFFFF};
            round_flags = 5'b00101;
        end else begin
            round_res   = {sign_q, exp_r[7:0], frac_r};
            round_flags = {4'd0, grs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            rm_q         <= '0;
            big_q        <= '0;
            small_q      <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            sign_q       <= 1'b0;
            zero_q       <= 1'b0;
            sum_q        <= '0;
            exp_q        <= '0;
            cnt_q        <= '0;
            out_valid    <= 1'b0;
            result       <= '0;
            fflags       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every state register updates from pre-edge values.
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= {b[31] ^ op, b[30:0]};
                    rm_q    <= rm;
                    state_q <= S_ALIGN;
                end
                S_ALIGN: begin
                    if (special) begin
                        result  <= special_res;
                        fflags  <= special_flags;
                        state_q <= S_DONE;
                    end else begin
                        big_q        <= {a_first ? ma : mb, 24'd0};
                        small_q      <= small_shift | {47'd0, small_lost};
                        sign_big_q   <= a_first ? a_q[31] : b_q[31];
                        sign_small_q <= a_first ? b_q[31] : a_q[31];
                        exp_q        <= {2'b00, e_big};
                        state_q      <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_q <= add_sum;
                    cnt_q <= '0;
                    if (add_sum == 49'd0) begin
                        zero_q  <= 1'b1;
                        sign_q  <= (rm_q == RM_RDN);
                        state_q <= S_ROUND;
                    end else begin
                        zero_q  <= 1'b0;
                        sign_q  <= add_sign;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (sum_q[48]) begin
                        sum_q   <= {1'b0, sum_q[48:2], sum_q[1] | sum_q[0]};
                        exp_q   <= exp_q + 10'd1;
                        state_q <= S_ROUND;
                    end else if (sum_q[47] || (cnt_q == CNT_MAX) || (exp_q <= 10'd1)) begin
                        state_q <= S_ROUND;
                    end else begin
                        sum_q <= {sum_q[47:0], 1'b0};
                        exp_q <= exp_q - 10'd1;
                        cnt_q <= cnt_inc;
                        // Leave as soon as this shift completes normalisation or hits a limit.
                        if (sum_q[46] || (cnt_inc == CNT_MAX) || (exp_q <= 10'd2))
                            state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    result  <= round_res;
                    fflags  <= round_flags;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FP_ADDSUB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready)  perf_ops   <= perf_ops + 32'd1;
            if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle sequencer for FP32 add/subtract in the rv32imf core's FP unit.
- Accepts one FADD.S/FSUB.S per transaction over a valid/ready handshake.
- Steps one shared datapath through unpack/align, signed-magnitude add/sub, iterative normalise and round, using an FSM.
- Returns an IEEE-754 binary32 result and RISC-V fflags over a second valid/ready handshake.

Parameters:
- NORM_MAX, 24, maximum left-shift iterations in NORM; also sets the width of the shift counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  1  0 = add, 1 = subtract (flips sign of b)
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
- a  in  32  operand 1
- b  in  32  operand 2
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  binary32 result
- fflags  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) clears state to IDLE. Reset values: in_ready=1, out_valid=0, result=0, fflags=0, busy=0. Reset mid-operation abandons the op; no output is produced.
- Acceptance: a request is accepted when in_valid && in_ready. At acceptance, a, b, op and rm are registered. in_ready=1 only in IDLE.
- IDLE -> ALIGN on accept.
- ALIGN (1 cycle):
  - Unpack operands. Subnormal inputs are flushed to signed zero.
  - Specials:
    - Any NaN -> result 0x7FC00000; NV=1 if either operand is sNaN.
    - inf + (-inf), after the op sign flip -> 0x7FC00000, NV=1.
    - A single inf -> that inf.
    - Special cases go directly to DONE.
  - Otherwise, swap operands so the larger exponent is first.
  - Right-shift the smaller 24-bit mantissa (hidden bit included) into a 48-bit field. Shift is capped at 48; shifted-out bits are ORed into sticky.
  - -> ADD.
- ADD (1 cycle):
  - Equal effective signs: 49-bit sum.
  - Otherwise: subtract the smaller magnitude from the larger; result takes the sign of the larger.
  - Exact zero result: +0 for all rm except RDN, which gives -0. Exact zero goes directly to ROUND with no flags.
  - -> NORM.
- NORM (max(1, L) cycles):
  - If the carry bit is set: one right shift (kept bit ORed into sticky), exponent+1, done in 1 cycle.
  - Else: left shift 1 bit per cycle and decrement the exponent until the MSB is set, the counter reaches NORM_MAX, or the exponent reaches 1.
  - -> ROUND.
- ROUND (1 cycle):
  - Guard/round/sticky rounding per rm. rm values 5-7 are treated as RNE.
  - A mantissa carry-out increments the exponent.
  - Exponent >= 255 -> OF|NX. Result is inf for RNE/RMM, or for RUP/RDN in the matching sign; otherwise 0x7F7FFFFF with sign.
  - Result below the minimum normal -> signed zero, UF|NX.
  - Any nonzero GRS -> NX.
  - -> DONE.
- DONE:
  - out_valid=1; result and fflags are held stable until out_ready.
  - On out_valid && out_ready -> IDLE. in_ready rises the next cycle; there is no same-cycle accept.
- Latency (accept edge to out_valid): 4 + max(1, L) cycles for normal operands; 2 cycles for special cases.
- Throughput: one operation in flight.

Optional Feature:
- Macro: FP_ADDSUB_PERF_EN.
- When defined, adds output ports perf_ops[31:0] and perf_stall[31:0].
  - perf_ops increments on each result handshake.
  - perf_stall increments each cycle with out_valid && !out_ready.
  - Both counters wrap at 2^32 and reset to 0 on rst_n.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. a=0x3F800000, b=0x40000000, op=0, rm=0 -> result 0x40400000, fflags 0, out_valid 5 cycles after accept.
2. a=0x3F800001, b=0x3F800000, op=1 -> result 0x34000000, fflags 0, L=23, out_valid 27 cycles after accept.
3. a=0x7F800001, b=0x3F800000 -> 0x7FC00000, NV=1, out_valid 2 cycles after accept. Also a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, NV=1.
4. a=b=0x7F7FFFFF, op=0: rm=0 -> 0x7F800000, fflags 0x05 (OF|NX); rm=1 -> 0x7F7FFFFF, fflags 0x05.
5. a=0x3F800000, b=0x33800000 (tie): rm=0 -> 0x3F800000, NX; rm=3 -> 0x3F800001, NX. a=0x3F800000, b=0x3F800000, op=1, rm=2 -> 0x80000000, fflags 0.
6. Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0. Then issue an op and pull rst_n low in NORM -> out_valid=0 and in_ready=1 immediately (async), with no stale result after release.
